// File: rtl/alu_decode_stage_if.sv
// Handshake and payload bundle between fetch, the ALU decode stage and execute.
// The stage takes the slave modport; the upstream/downstream driver takes master.
interface alu_decode_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  InValid_i;
    logic                  InReady_o;
    logic [DATA_WIDTH-1:0] Instr_i;
    logic [DATA_WIDTH-1:0] PC_i;
    logic                  Flush_i;
    logic                  OutValid_o;
    logic                  OutReady_i;
    logic [2:0]            ALUControl_o;
    logic                  ALUSrcB_o;
    logic [DATA_WIDTH-1:0] ImmExt_o;
    logic                  RegWrite_o;
    logic                  MemWrite_o;
    logic [1:0]            ResultSrc_o;
    logic [1:0]            Branch_o;
    logic                  Jump_o;
    logic                  Illegal_o;
    logic [DATA_WIDTH-1:0] PC_o;

    modport slave (
        input  InValid_i, Instr_i, PC_i, Flush_i, OutReady_i,
        output InReady_o, OutValid_o, ALUControl_o, ALUSrcB_o, ImmExt_o, RegWrite_o,
               MemWrite_o, ResultSrc_o, Branch_o, Jump_o, Illegal_o, PC_o
    );

    modport master (
        output InValid_i, Instr_i, PC_i, Flush_i, OutReady_i,
        input  InReady_o, OutValid_o, ALUControl_o, ALUSrcB_o, ImmExt_o, RegWrite_o,
               MemWrite_o, ResultSrc_o, Branch_o, Jump_o, Illegal_o, PC_o
    );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I subset decoder producing ALU-side controls, registered in a one-entry
// valid/ready slot that feeds the execute stage.
module alu_decode_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                clk_i,
    input logic                rst_i,
    alu_decode_stage_if.slave  bus
);
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluPass = 3'b100;
    localparam logic [2:0] AluSlt  = 3'b101;
    localparam logic [2:0] AluSll  = 3'b110;

    typedef struct packed {
        logic [2:0]            alu_ctrl;
        logic                  alu_src_b;
        logic [DATA_WIDTH-1:0] imm;
        logic                  reg_write;
        logic                  mem_write;
        logic [1:0]            result_src;
        logic [1:0]            branch;
        logic                  jump;
        logic                  illegal;
    } dec_t;

    logic [DATA_WIDTH-1:0] instr;
    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    dec_t                  dec;
    logic                  legal;

    assign instr  = bus.Instr_i;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(DATA_WIDTH-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(DATA_WIDTH-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OpR: begin
                dec.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.alu_ctrl = AluAdd;
                        3'b111:  dec.alu_ctrl = AluAnd;
                        3'b110:  dec.alu_ctrl = AluOr;
                        3'b010:  dec.alu_ctrl = AluSlt;
                        3'b001:  dec.alu_ctrl = AluSll;
                        default: legal = 1'b0;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.alu_ctrl = AluSub;
                end else begin
                    legal = 1'b0;
                end
            end
            OpI: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_i;
                case (f3)
                    3'b000:  dec.alu_ctrl = AluAdd;
                    3'b111:  dec.alu_ctrl = AluAnd;
                    3'b110:  dec.alu_ctrl = AluOr;
                    3'b010:  dec.alu_ctrl = AluSlt;
                    3'b001: begin
                        dec.alu_ctrl = AluSll;
                        legal        = (f7 == 7'b0000000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OpLoad: begin
                legal          = (f3 == 3'b010);
                dec.alu_src_b  = 1'b1;
                dec.imm        = imm_i;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
            end
            OpStore: begin
                legal         = (f3 == 3'b010);
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
            end
            OpBranch: begin
                dec.alu_ctrl = AluSub;
                dec.imm      = imm_b;
                case (f3)
                    3'b000:  dec.branch = 2'b01;
                    3'b001:  dec.branch = 2'b10;
                    default: legal = 1'b0;
                endcase
            end
            OpLui: begin
                dec.alu_ctrl  = AluPass;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OpJal: begin
                dec.imm        = imm_j;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
            end
            default: legal = 1'b0;
        endcase
        // Unsupported encodings must not leak any partial control.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    logic                  valid_q, valid_d;
    dec_t                  dec_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  in_ready;
    logic                  capture;

    assign in_ready = !valid_q || bus.OutReady_i || bus.Flush_i;
    assign capture  = bus.InValid_i && in_ready && !bus.Flush_i;

    always_comb begin
        valid_d = valid_q;
        if (bus.Flush_i) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.OutReady_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                dec_q <= dec;
                pc_q  <= bus.PC_i;
            end
        end
    end

    assign bus.InReady_o    = in_ready;
    assign bus.OutValid_o   = valid_q;
    assign bus.ALUControl_o = dec_q.alu_ctrl;
    assign bus.ALUSrcB_o    = dec_q.alu_src_b;
    assign bus.ImmExt_o     = dec_q.imm;
    assign bus.RegWrite_o   = dec_q.reg_write;
    assign bus.MemWrite_o   = dec_q.mem_write;
    assign bus.ResultSrc_o  = dec_q.result_src;
    assign bus.Branch_o     = dec_q.branch;
    assign bus.Jump_o       = dec_q.jump;
    assign bus.Illegal_o    = dec_q.illegal;
    assign bus.PC_o         = pc_q;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: mnemonic-level reference model checked every
// cycle, plus hand-computed vectors for decode, stall, flush and async reset.
module tb_alu_decode_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_decode_stage_if #(.DATA_WIDTH(DW)) bus ();
    alu_decode_stage #(.DATA_WIDTH(DW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef enum {
        MAdd, MSub, MAnd, MOr, MSlt, MSll, MAddi, MAndi, MOri, MSlti, MSlli,
        MLw, MSw, MBeq, MBne, MLui, MJal, MIll
    } mn_t;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic        srcb;
        logic [31:0] imm;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [1:0]  br;
        logic        j;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    function automatic mn_t classify(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        int         fn = int'(w[14:12]);
        logic [6:0] hi = w[31:25];
        if (op == 7'h33 && hi == 7'h00) begin
            if (fn == 0) return MAdd;
            if (fn == 7) return MAnd;
            if (fn == 6) return MOr;
            if (fn == 2) return MSlt;
            if (fn == 1) return MSll;
        end
        if (op == 7'h33 && hi == 7'h20 && fn == 0) return MSub;
        if (op == 7'h13) begin
            if (fn == 0) return MAddi;
            if (fn == 7) return MAndi;
            if (fn == 6) return MOri;
            if (fn == 2) return MSlti;
            if (fn == 1 && hi == 7'h00) return MSlli;
        end
        if (op == 7'h03 && fn == 2) return MLw;
        if (op == 7'h23 && fn == 2) return MSw;
        if (op == 7'h63 && fn == 0) return MBeq;
        if (op == 7'h63 && fn == 1) return MBne;
        if (op == 7'h37) return MLui;
        if (op == 7'h6F) return MJal;
        return MIll;
    endfunction

    function automatic exp_t expect_of(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e = '0;
        mn_t         m = classify(w);
        logic [31:0] sw = w;
        logic [31:0] i_imm = 32'($signed(sw) >>> 20);
        logic [31:0] s_imm = (32'($signed(sw) >>> 25) << 5) | 32'(w[11:7]);
        logic [31:0] b_imm = (32'($signed(sw) >>> 31) << 12) | (32'(w[7]) << 11)
                             | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        logic [31:0] j_imm = (32'($signed(sw) >>> 31) << 20) | (32'(w[19:12]) << 12)
                             | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        e.pc = pc;
        case (m)
            MAdd, MAddi: e.ctrl = 3'd0;
            MSub:        e.ctrl = 3'd1;
            MAnd, MAndi: e.ctrl = 3'd2;
            MOr, MOri:   e.ctrl = 3'd3;
            MSlt, MSlti: e.ctrl = 3'd5;
            MSll, MSlli: e.ctrl = 3'd6;
            MBeq, MBne:  e.ctrl = 3'd1;
            MLui:        e.ctrl = 3'd4;
            default:     e.ctrl = 3'd0;
        endcase
        e.srcb = m inside {MAddi, MAndi, MOri, MSlti, MSlli, MLw, MSw, MLui};
        if (m inside {MAddi, MAndi, MOri, MSlti, MSlli, MLw}) e.imm = i_imm;
        if (m == MSw) e.imm = s_imm;
        if (m inside {MBeq, MBne}) e.imm = b_imm;
        if (m == MLui) e.imm = w & 32'hFFFF_F000;
        if (m == MJal) e.imm = j_imm;
        e.rw  = !(m inside {MSw, MBeq, MBne, MIll});
        e.mw  = (m == MSw);
        e.rs  = (m == MLw) ? 2'b01 : (m == MJal) ? 2'b10 : 2'b00;
        e.br  = (m == MBeq) ? 2'b01 : (m == MBne) ? 2'b10 : 2'b00;
        e.j   = (m == MJal);
        e.ill = (m == MIll);
        return e;
    endfunction

    // Transaction-level view of the slot: what execute should be seeing.
    logic m_valid = 1'b0;
    exp_t m_slot  = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_slot  <= '0;
        end else if (bus.Flush_i) begin
            m_valid <= 1'b0;
        end else if (bus.InValid_i && (!m_valid || bus.OutReady_i)) begin
            m_valid <= 1'b1;
            m_slot  <= expect_of(bus.Instr_i, bus.PC_i);
        end else if (bus.OutReady_i) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(bus.InReady_o),
                32'(!m_valid || bus.OutReady_i || bus.Flush_i));
            chk("out_valid", 32'(bus.OutValid_o), 32'(m_valid));
            if (m_valid) begin
                chk("m_alu_ctrl", 32'(bus.ALUControl_o), 32'(m_slot.ctrl));
                chk("m_src_b", 32'(bus.ALUSrcB_o), 32'(m_slot.srcb));
                chk("m_imm", bus.ImmExt_o, m_slot.imm);
                chk("m_reg_write", 32'(bus.RegWrite_o), 32'(m_slot.rw));
                chk("m_mem_write", 32'(bus.MemWrite_o), 32'(m_slot.mw));
                chk("m_result_src", 32'(bus.ResultSrc_o), 32'(m_slot.rs));
                chk("m_branch", 32'(bus.Branch_o), 32'(m_slot.br));
                chk("m_jump", 32'(bus.Jump_o), 32'(m_slot.j));
                chk("m_illegal", 32'(bus.Illegal_o), 32'(m_slot.ill));
                chk("m_pc", bus.PC_o, m_slot.pc);
            end
        end
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  ctrl;
        logic        srcb;
        logic [31:0] imm;
        logic        rw;
        logic [1:0]  br;
        logic        ill;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV] = '{
        '{32'h002081B3, 3'd0, 1'b0, 32'h00000000, 1'b1, 2'b00, 1'b0},  // add
        '{32'h402081B3, 3'd1, 1'b0, 32'h00000000, 1'b1, 2'b00, 1'b0},  // sub
        '{32'hFFF00093, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0},  // addi -1
        '{32'h123452B7, 3'd4, 1'b1, 32'h12345000, 1'b1, 2'b00, 1'b0},  // lui
        '{32'hFE208CE3, 3'd1, 1'b0, 32'hFFFFFFF8, 1'b0, 2'b01, 1'b0},  // beq -8
        '{32'hFFFFFFFF, 3'd0, 1'b0, 32'h00000000, 1'b0, 2'b00, 1'b1},  // illegal
        '{32'h00812283, 3'd0, 1'b1, 32'h00000008, 1'b1, 2'b00, 1'b0},  // lw 8
        '{32'hFE512E23, 3'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 2'b00, 1'b0},  // sw -4
        '{32'h010000EF, 3'd0, 1'b0, 32'h00000010, 1'b1, 2'b00, 1'b0},  // jal +16
        '{32'h00309093, 3'd6, 1'b1, 32'h00000003, 1'b1, 2'b00, 1'b0},  // slli 3
        '{32'h40309093, 3'd0, 1'b0, 32'h00000000, 1'b0, 2'b00, 1'b1},  // slli, bad f7
        '{32'h00209463, 3'd1, 1'b0, 32'h00000008, 1'b0, 2'b10, 1'b0}   // bne +8
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.InValid_i  = 1'b0;
        bus.Instr_i    = '0;
        bus.PC_i       = '0;
        bus.Flush_i    = 1'b0;
        bus.OutReady_i = 1'b0;
        repeat (2) step();
        chk("rst_out_valid", 32'(bus.OutValid_o), 32'd0);
        chk("rst_pc", bus.PC_o, 32'd0);
        chk("rst_imm", bus.ImmExt_o, 32'd0);
        rst = 1'b0;
        bus.OutReady_i = 1'b1;

        // Back-to-back decode vectors, one capture per cycle.
        for (int i = 0; i < NV; i++) begin
            bus.InValid_i = 1'b1;
            bus.Instr_i   = tbl[i].instr;
            bus.PC_i      = 32'h1000 + 32'(4 * i);
            step();
            chk("v_valid", 32'(bus.OutValid_o), 32'd1);
            chk("v_ctrl", 32'(bus.ALUControl_o), 32'(tbl[i].ctrl));
            chk("v_src_b", 32'(bus.ALUSrcB_o), 32'(tbl[i].srcb));
            chk("v_imm", bus.ImmExt_o, tbl[i].imm);
            chk("v_reg_write", 32'(bus.RegWrite_o), 32'(tbl[i].rw));
            chk("v_branch", 32'(bus.Branch_o), 32'(tbl[i].br));
            chk("v_illegal", 32'(bus.Illegal_o), 32'(tbl[i].ill));
            chk("v_pc", bus.PC_o, 32'h1000 + 32'(4 * i));
        end
        bus.InValid_i = 1'b0;
        step();
        chk("drain_valid", 32'(bus.OutValid_o), 32'd0);

        // Stall: slot holds add while lui waits upstream.
        bus.InValid_i  = 1'b1;
        bus.Instr_i    = 32'h002081B3;
        bus.PC_i       = 32'h2000;
        bus.OutReady_i = 1'b0;
        step();
        bus.Instr_i = 32'h123452B7;
        bus.PC_i    = 32'h2004;
        repeat (3) begin
            step();
            chk("stall_in_ready", 32'(bus.InReady_o), 32'd0);
            chk("stall_pc", bus.PC_o, 32'h2000);
            chk("stall_ctrl", 32'(bus.ALUControl_o), 32'd0);
            chk("stall_valid", 32'(bus.OutValid_o), 32'd1);
        end
        bus.OutReady_i = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.InReady_o), 32'd1);
        step();
        chk("release_pc", bus.PC_o, 32'h2004);
        chk("release_ctrl", 32'(bus.ALUControl_o), 32'd4);

        // Flush with slot full and a new word offered: both disappear.
        bus.Instr_i    = 32'h402081B3;
        bus.PC_i       = 32'h3000;
        bus.OutReady_i = 1'b0;
        bus.Flush_i    = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.InReady_o), 32'd1);
        step();
        chk("flush_valid", 32'(bus.OutValid_o), 32'd0);
        bus.Flush_i   = 1'b0;
        bus.InValid_i = 1'b0;
        repeat (2) begin
            step();
            chk("flush_stays_empty", 32'(bus.OutValid_o), 32'd0);
            chk("flush_no_load", bus.PC_o, 32'h2004);
        end

        // Async reset asserted mid-cycle during a stall.
        bus.InValid_i = 1'b1;
        bus.Instr_i   = 32'h010000EF;
        bus.PC_i      = 32'h4000;
        step();
        chk("pre_rst_valid", 32'(bus.OutValid_o), 32'd1);
        chk("pre_rst_jump", 32'(bus.Jump_o), 32'd1);
        bus.InValid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.OutValid_o), 32'd0);
        chk("arst_pc", bus.PC_o, 32'd0);
        chk("arst_imm", bus.ImmExt_o, 32'd0);
        chk("arst_jump", 32'(bus.Jump_o), 32'd0);
        chk("arst_reg_write", 32'(bus.RegWrite_o), 32'd0);
        chk("arst_result_src", 32'(bus.ResultSrc_o), 32'd0);
        #2;
        rst = 1'b0;
        bus.InValid_i  = 1'b1;
        bus.Instr_i    = 32'hFFF00093;
        bus.PC_i       = 32'h5000;
        bus.OutReady_i = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.OutValid_o), 32'd1);
        chk("post_rst_pc", bus.PC_o, 32'h5000);
        bus.InValid_i = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
